apb_slave_regbank: RTL and testbench



---
 rtl/apb_slave_regbank.sv | 122 ++++++++++++
 tb/tb_apb_slave_regbank.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// Parametrised APB4 slave register bank: RW/RO registers, byte strobes,
// programmable wait states, PSLVERR on bad decode, per-register write pulses.
module apb_slave_regbank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                             state_q, state_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d;
    logic [ADDR_WIDTH-1:0]              offset;
    logic [IW-1:0]                      idx;
    logic                               in_range, err, commit, rd_en;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] view;

    // Address decode and error classification
    always_comb begin
        offset   = PADDR - BASE_ADDR;
        idx      = offset[IW+1:2];
        in_range = (offset >> 2) < ADDR_WIDTH'(NUM_REGS);
        err      = (PADDR < BASE_ADDR) || (PADDR[1:0] != 2'b00) || !in_range ||
                   (PWRITE && in_range && RO_MASK[idx]);
    end

    always_comb begin
        PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
        PSLVERR = PREADY && err;
        commit  = PREADY && PWRITE && !err;
        rd_en   = (state_q == ACCESS) && PSEL && PENABLE && !PWRITE && !err;
        PRDATA  = rd_en ? view[idx] : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!PSEL || PREADY) state_d = IDLE;
                else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_pulse_d = '0;
        if (commit) wr_pulse_d[idx] = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse = wr_pulse_q;

    // Read-only slots carry no storage: they expose status_in live.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign view[i] = status_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] reg_q, reg_d;
            logic                  unused_status;

            assign unused_status = ^status_in[i*DATA_WIDTH +: DATA_WIDTH];

            always_comb begin
                reg_d = reg_q;
                if (commit && (idx == IW'(i))) begin
                    for (int b = 0; b < NB; b++) begin
                        if (PSTRB[b]) reg_d[b*8 +: 8] = PWDATA[b*8 +: 8];
                    end
                end
            end

            always_ff @(posedge PCLK or posedge PRESET) begin
                if (PRESET) reg_q <= RESET_VAL;
                else        reg_q <= reg_d;
            end

            assign view[i] = reg_q;
        end
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = view[i];
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: a wait-stated bank with one RO register and a
// zero-wait bank, checked against an array-based model of the register map.
module tb_apb_slave_regbank;
    localparam int         N  = 8;
    localparam int         DW = 32;
    localparam int         WS = 1;
    localparam logic [31:0] RV = 32'h5A5A_0000;
    localparam logic [7:0]  RO = 8'h08;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic [31:0]       paddr = '0, pwdata = '0;
    logic              psel1 = 1'b0, psel0 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]        pstrb = '0;
    logic [N*DW-1:0]   status_in = '0;
    logic [N*DW-1:0]   reg_out1, reg_out0;
    logic [31:0]       prdata1, prdata0;
    logic              pready1, pready0, pslverr1, pslverr0;
    logic [N-1:0]      wr_pulse1, wr_pulse0;

    int                n_tests = 0, n_fail = 0;
    int                pulse_seen = 0, pulse_exp = 0;
    logic [31:0]       m1 [N];
    logic [31:0]       m0 [N];
    logic [31:0]       last_rd;

    always #5 PCLK = ~PCLK;

    apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .NUM_REGS(N), .BASE_ADDR(32'h0),
                        .WAIT_STATES(WS), .RO_MASK(RO), .RESET_VAL(RV)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel1), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
        .PSLVERR(pslverr1), .status_in(status_in), .reg_out(reg_out1), .wr_pulse(wr_pulse1));

    apb_slave_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .NUM_REGS(N), .BASE_ADDR(32'h0),
                        .WAIT_STATES(0), .RO_MASK('0), .RESET_VAL('0)) u_dut_z (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(paddr), .PSEL(psel0), .PENABLE(penable),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .status_in(status_in), .reg_out(reg_out0), .wr_pulse(wr_pulse0));

    always @(negedge PCLK) pulse_seen += $countones(wr_pulse1) + $countones(wr_pulse0);

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit m_err(bit z, bit wr, logic [31:0] a);
        bit inr;
        inr = a < 32'(N * 4);
        return (a[1:0] != 2'b00) || !inr || (wr && inr && !z && RO[a[4:2]]);
    endfunction

    function automatic logic [31:0] m_val(bit z, int i);
        if (!z && RO[i]) return status_in[i*DW +: DW];
        return z ? m0[i] : m1[i];
    endfunction

    function automatic logic [N*DW-1:0] exp_regs(bit z);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = m_val(z, i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m1[i] = RV;
            m0[i] = '0;
        end
    endtask

    task automatic idle();
        @(negedge PCLK);
        psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
    endtask

    // One complete transfer; leaves PSEL high so the next call is back-to-back.
    task automatic xfer(input bit z, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int          cyc, i;
        bit          e;
        logic [31:0] exp_rd;
        logic [N-1:0] exp_p;
        @(negedge PCLK);
        psel1 = !z; psel0 = z; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge PCLK);
        penable = 1'b1;
        #1;
        cyc = 2;
        while (!(z ? pready0 : pready1) && cyc < 40) begin
            chk("slverr_wait", z ? pslverr0 : pslverr1, 1'b0);
            @(negedge PCLK);
            #1;
            cyc++;
        end
        e      = m_err(z, wr, a);
        i      = int'(a[4:2]);
        exp_rd = (!wr && !e) ? m_val(z, i) : 32'h0;
        last_rd = z ? prdata0 : prdata1;
        chk("latency", cyc, z ? 2 : WS + 2);
        chk("prdata", last_rd, exp_rd);
        chk("pslverr", z ? pslverr0 : pslverr1, e);
        exp_p = '0;
        if (wr && !e) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (z) m0[i][b*8 +: 8] = d[b*8 +: 8];
                    else   m1[i][b*8 +: 8] = d[b*8 +: 8];
                end
            end
            exp_p[i] = 1'b1;
            pulse_exp++;
        end
        @(posedge PCLK);
        #1;
        chk("wr_pulse", z ? wr_pulse0 : wr_pulse1, exp_p);
        chk("reg_out", z ? reg_out0 : reg_out1, exp_regs(z));
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        model_reset();
        for (int i = 0; i < N; i++) status_in[i*DW +: DW] = $urandom;
        repeat (2) @(negedge PCLK);
        #1;
        chk("rst_pready", {pready1, pready0}, 2'b00);
        chk("rst_pslverr", {pslverr1, pslverr0}, 2'b00);
        chk("rst_prdata", {prdata1, prdata0}, 64'h0);
        chk("rst_pulse", {wr_pulse1, wr_pulse0}, 16'h0);
        chk("rst_regs1", reg_out1, exp_regs(1'b0));
        chk("rst_regs0", reg_out0, exp_regs(1'b1));
        PRESET = 1'b0;

        xfer(0, 1, 32'h08, 32'hCAFE_F00D, 4'hF);
        xfer(0, 0, 32'h08, 32'h0, 4'h0);
        chk("cafe", last_rd, 32'hCAFE_F00D);

        xfer(0, 1, 32'h04, 32'h1122_3344, 4'hF);
        xfer(0, 1, 32'h04, 32'hAABB_CCDD, 4'b0101);
        xfer(0, 0, 32'h04, 32'h0, 4'hF);
        chk("strb_merge", last_rd, 32'h11BB_33DD);
        xfer(0, 1, 32'h04, 32'hFFFF_FFFF, 4'h0);
        xfer(0, 0, 32'h04, 32'h0, 4'h0);
        chk("strb_zero", last_rd, 32'h11BB_33DD);

        idle();
        status_in[3*DW +: DW] = 32'h0000_00A5;
        xfer(0, 0, 32'h0C, 32'h0, 4'h0);
        chk("ro_read", last_rd, 32'h0000_00A5);
        xfer(0, 1, 32'h0C, 32'h1234_5678, 4'hF);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0);
        chk("ro_keep", last_rd, 32'h0000_00A5);

        xfer(0, 0, 32'h20, 32'h0, 4'h0);
        xfer(0, 0, 32'h05, 32'h0, 4'h0);
        xfer(0, 1, 32'h20, 32'hDEAD_BEEF, 4'hF);
        idle();

        xfer(1, 1, 32'h00, 32'h0102_0304, 4'hF);
        xfer(1, 1, 32'h04, 32'h0506_0708, 4'hF);
        xfer(1, 0, 32'h00, 32'h0, 4'h0);
        xfer(1, 0, 32'h04, 32'h0, 4'h0);
        chk("z_read", last_rd, 32'h0506_0708);
        idle();

        // Aborted transfer: setup then PSEL dropped
        @(negedge PCLK);
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hBAD0_BAD0; pstrb = 4'hF;
        @(negedge PCLK);
        psel1 = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        chk("abort_regs", reg_out1, exp_regs(1'b0));
        xfer(0, 0, 32'h00, 32'h0, 4'h0);

        // Reset in the cycle where PREADY would complete a write
        @(negedge PCLK);
        psel1 = 1'b1; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0;
        pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(negedge PCLK);
        penable = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        chk("mid_rst_pready", pready1, 1'b0);
        chk("mid_rst_prdata", prdata1, 32'h0);
        chk("mid_rst_pslverr", pslverr1, 1'b0);
        model_reset();
        @(negedge PCLK);
        PRESET = 1'b0; psel1 = 1'b0; penable = 1'b0;
        #1;
        chk("mid_rst_regs1", reg_out1, exp_regs(1'b0));
        chk("mid_rst_regs0", reg_out0, exp_regs(1'b1));
        xfer(0, 1, 32'h00, 32'h7777_8888, 4'hF);
        xfer(0, 0, 32'h00, 32'h0, 4'h0);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(7, 0));
            if (r <= 5)      a = {27'h0, 3'($urandom), 2'b00};
            else if (r == 6) a = 32'h20 + {26'h0, 4'($urandom), 2'b00};
            else             a = 32'($urandom_range(63, 0));
            xfer($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, a, $urandom, 4'($urandom));
            if ($urandom_range(7, 0) == 0) begin
                idle();
                for (int i = 0; i < N; i++) status_in[i*DW +: DW] = $urandom;
            end
        end
        idle();
        repeat (3) @(negedge PCLK);
        chk("pulse_count", pulse_seen, pulse_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
